// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: drains the FIFO in bursts into a 2-entry skid buffer.
// Optional FIFO_RD_URGENT_EN: keep bursting while the FIFO is programmable-full.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  burst_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [8:0] LEN = 9'(BURST_LEN);
  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       done_q, done_d;

  logic [1:0]            buf_count_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_mem_q [2];

  logic       issue;
  logic       pop;
  logic [8:0] cnt_next;
  logic [7:0] cnt_sat;
  logic       len_hit;
  logic       skip_gap;
  logic       term;

  // Read request depends only on registered state, fifo_empty and flush.
  assign fifo_rd_en = (state_q == BURST) & ~fifo_empty
                    & (buf_count_q != 2'd2) & ~flush;
  assign issue      = fifo_rd_en & ~fifo_empty;
  assign m_valid    = (buf_count_q != 2'd0);
  assign pop        = m_valid & m_ready;
  assign m_data     = buf_mem_q[rd_ptr_q];
  assign busy       = (state_q == BURST);
  assign burst_done = done_q;

  assign cnt_next = {1'b0, burst_cnt_q} + {8'd0, issue};
  assign cnt_sat  = cnt_next[8] ? 8'hFF : cnt_next[7:0];

`ifdef FIFO_RD_URGENT_EN
  assign len_hit  = (cnt_next >= LEN) & ~fifo_full;
  assign skip_gap = fifo_full;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign len_hit  = (cnt_next >= LEN);
  assign skip_gap = 1'b0;
`endif

  assign term = fifo_empty | len_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= 8'd0;
      gap_cnt_q   <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      burst_cnt_d = 8'd0;
      gap_cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state_d     = BURST;
            burst_cnt_d = 8'd0;
          end
        end
        BURST: begin
          burst_cnt_d = cnt_sat;
          if (term) begin
            done_d    = 1'b1;
            gap_cnt_d = 4'd0;
            if (GAP_CYCLES == 0 || skip_gap) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = IDLE;
            gap_cnt_d = 4'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The issue rule never pushes into a full buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_count_q  <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_mem_q[0] <= '0;
      buf_mem_q[1] <= '0;
    end else if (flush) begin
      buf_count_q <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      if (issue) begin
        buf_mem_q[wr_ptr_q] <= fifo_data;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case (1'b1)
        issue & ~pop: buf_count_q <= buf_count_q + 2'd1;
        pop & ~issue: buf_count_q <= buf_count_q - 2'd1;
        default:      buf_count_q <= buf_count_q;
      endcase
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 64x8 programmable-threshold FIFO. Watches the FIFO's programmable-empty and programmable-full flags and issues read bursts. Captures the memory read data into a 2-entry output buffer and presents it downstream on a valid/ready stream. Sits between the FIFO's read port and the consuming datapath.

## Interface
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- BURST_LEN, 16, maximum reads per burst, range 1..255.
- GAP_CYCLES, 2, idle cycles forced between bursts, range 0..15.

- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO programmable-empty flag (occupancy <= empty threshold); the FIFO drops rd_en while high.
- fifo_full  input  1  FIFO programmable-full flag; used only with FIFO_RD_URGENT_EN.
- fifo_rd_en  output  1  read request to the FIFO.
- fifo_data  input  DATA_WIDTH  FIFO read data.
- enable  input  1  allows new bursts to start; sampled in IDLE only.
- flush  input  1  synchronous abort; clears the buffer and returns to IDLE.
- m_data  output  DATA_WIDTH  output word (head of buffer).
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accept.
- busy  output  1  high in BURST.
- burst_done  output  1  one-cycle pulse on burst termination.

## Operation
- FSM states: IDLE, BURST, GAP.
- IDLE → BURST when enable=1 and fifo_empty=0. The burst counter clears on entry.
- BURST:
  - fifo_rd_en = ~fifo_empty & (buf_count < 2). It is a registered-state function only; no combinational path from m_ready.
  - Issued read = fifo_rd_en & ~fifo_empty. Only issued reads increment the burst counter.
  - Terminates after the cycle in which issued count reaches BURST_LEN, or in the first BURST cycle where fifo_empty=1 (short burst).
  - On termination: burst_done pulses for one cycle and the FSM goes to GAP.
- GAP: counts GAP_CYCLES cycles, then returns to IDLE. With GAP_CYCLES=0 it goes directly to IDLE and spends 0 cycles in GAP.
- Output buffer: 2-entry FIFO with registered buf_count 0..2.
  - Push on an issued read; pop on m_valid & m_ready.
  - Simultaneous push and pop leave the count unchanged.
  - m_valid = (buf_count != 0).
  - Overflow cannot occur: the issue rule guarantees it.
- flush (any state) wins over all other events that cycle:
  - fifo_rd_en forced 0 that cycle.
  - Buffer cleared: buf_count=0 and m_valid=0 on the next cycle.
  - FSM → IDLE, burst counter cleared.
  - No burst_done pulse.
- enable deasserted mid-burst does not abort the burst.
- Counter widths: burst counter is 8 bits; gap counter is 4 bits. Neither wraps inside legal parameter ranges.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, burst_done=0, FSM=IDLE, buf_count=0, both counters 0.
- FIFO memory is clocked on the inverted clock. Read data for a read issued in cycle N is valid on fifo_data before the rising edge that ends cycle N. The reader captures it at that edge.
- Latency: read issued in cycle N → m_valid=1 with that word in cycle N+1.
- First fifo_rd_en occurs in the cycle after the IDLE→BURST transition.
- Throughput: one word per cycle while m_ready=1 and fifo_empty=0. Steady state is buf_count=1.
- With m_ready=0, at most 2 reads are issued and fifo_rd_en then stays low until a pop.
- burst_done is asserted in the first GAP cycle. With GAP_CYCLES=0 it is asserted in the first IDLE cycle after BURST.
- busy falls in that same cycle.
- Asynchronous reset mid-burst: all outputs go to reset values immediately; buffered data is lost.

## Configuration
- FIFO_RD_URGENT_EN defined:
  - While fifo_full=1, the BURST_LEN limit is ignored. The burst continues until fifo_full=0 and issued count >= BURST_LEN, or until fifo_empty=1.
  - GAP is skipped (BURST → IDLE) if fifo_full=1 at termination.
- FIFO_RD_URGENT_EN undefined: fifo_full is ignored and bursts never exceed BURST_LEN.

## Test plan
- Preload 40 words (0x00..0x27), m_ready=1, enable=1 → 16 consecutive reads; m_data 0x00..0x0F on 16 consecutive cycles; burst_done pulses once; next burst starts after GAP+1 cycles.
- FIFO at 20 words (empty threshold 16) → short burst: exactly 4 issued reads (0x00..0x03), terminates when fifo_empty rises, burst_done pulses once.
- m_ready=0 for 10 cycles during a burst → exactly 2 issued reads, buf_count=2, no data lost; release m_ready → words continue in order with no duplicates.
- flush asserted with buf_count=2 mid-burst → next cycle m_valid=0, busy=0, FSM IDLE, no burst_done; following burst resumes from the next unread FIFO word.
- reset_n pulsed low mid-burst → all outputs 0 at once and remain 0 until the first rising edge after release.
- With FIFO_RD_URGENT_EN and fifo_full held high for 30 words → burst issues >16 reads without a gap; without the macro → exactly 16 reads, then GAP.
